// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: groups the comparator indications, brightness setting and
// LED-side outputs of rgb_pwm_driver into one bundle.
//   red_in/green_in/blue_in : comparator indications (asynchronous to clk)
//   duty                    : steady-state PWM brightness
//   led_r/led_g/led_b       : registered LED drives
//   update_pulse            : one-cycle pulse on colour acceptance
//   busy                    : high while settling or flashing
// master = the side driving the indications (comparator / bench),
// slave  = the driver itself.
interface rgb_pwm_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                red_in;
    logic                green_in;
    logic                blue_in;
    logic [PWM_BITS-1:0] duty;
    logic                led_r;
    logic                led_g;
    logic                led_b;
    logic                update_pulse;
    logic                busy;

    modport master (
        output red_in, green_in, blue_in, duty,
        input  led_r, led_g, led_b, update_pulse, busy
    );

    modport slave (
        input  red_in, green_in, blue_in, duty,
        output led_r, led_g, led_b, update_pulse, busy
    );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: synchronises and glitch-filters the comparator colour vector,
// flashes each newly accepted colour at full brightness, then holds it at the
// programmed PWM brightness.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : rgb_pwm_driver_if.slave (indications, duty, LED drives, status)
module rgb_pwm_driver #(
    parameter int PWM_BITS      = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int FLASH_CYCLES  = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    rgb_pwm_driver_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    typedef enum logic [1:0] {STEADY, SETTLE, FLASH} state_t;

    state_t              state;
    logic [2:0]          sync1;
    logic [2:0]          s;
    logic [2:0]          cand;
    logic [2:0]          acc;
    logic [SW-1:0]       stable_cnt;
    logic [FW-1:0]       flash_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                accept;
    logic [2:0]          led;
    logic                update_pulse;
    logic                busy;
    logic                pwm_on;

    // All-ones duty must mean fully on; a plain compare would leave one
    // dark slot per period.
    assign pwm_on = (bus.duty == '1) | (pwm_cnt < bus.duty);

    // Two-flop synchroniser per colour bit, plus the free-running PWM counter
    // (never restarted by colour events so brightness stays jitter-free).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 3'b000;
            s       <= 3'b000;
            pwm_cnt <= '0;
        end else begin
            sync1   <= {bus.red_in, bus.green_in, bus.blue_in};
            s       <= sync1;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Filter FSM. Outputs are registered from the pre-edge state, so they lag
    // the state/counters by one cycle; update_pulse goes through 'accept' to
    // line up with the first flash cycle on the LEDs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= STEADY;
            cand         <= 3'b000;
            acc          <= 3'b000;
            stable_cnt   <= '0;
            flash_cnt    <= '0;
            accept       <= 1'b0;
            update_pulse <= 1'b0;
            busy         <= 1'b0;
            led          <= 3'b000;
        end else begin
            accept       <= 1'b0;
            update_pulse <= accept;
            busy         <= (state != STEADY);
            led          <= (state == FLASH) ? acc : (acc & {3{pwm_on}});

            case (state)
                STEADY: begin
                    if (s != acc) begin
                        state      <= SETTLE;
                        cand       <= s;
                        stable_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (s == acc) begin
                        // change withdrawn before it qualified
                        state <= STEADY;
                    end else if (s != cand) begin
                        // still bouncing: restart qualification on the new value
                        cand       <= s;
                        stable_cnt <= '0;
                    end else if (stable_cnt == SW'(STABLE_CYCLES - 1)) begin
                        acc       <= cand;
                        accept    <= 1'b1;
                        state     <= FLASH;
                        flash_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end
                FLASH: begin
                    // inputs ignored; any pending difference is picked up in STEADY
                    flash_cnt <= flash_cnt + FW'(1);
                    if (flash_cnt == FW'(FLASH_CYCLES - 1)) state <= STEADY;
                end
                default: state <= STEADY;
            endcase
        end
    end

    assign bus.led_r        = led[2];
    assign bus.led_g        = led[1];
    assign bus.led_b        = led[0];
    assign bus.update_pulse = update_pulse;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver (PWM_BITS=4, STABLE_CYCLES=4, FLASH_CYCLES=3).
// Inputs change on the falling edge after rising edge 0 of each scenario;
// outputs are sampled on the falling edge after rising edge k.
module tb_rgb_pwm_driver;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rgb_pwm_driver_if #(.PWM_BITS(4)) bus ();

    rgb_pwm_driver #(
        .PWM_BITS(4),
        .STABLE_CYCLES(4),
        .FLASH_CYCLES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rgb(input logic [2:0] v);
        {bus.red_in, bus.green_in, bus.blue_in} = v;
    endtask

    task automatic chk_all(input string tag, input int k, input logic [2:0] led_e,
                           input logic pulse_e, input logic busy_e);
        chk($sformatf("%s k%0d led", tag, k), {5'd0, bus.led_r, bus.led_g, bus.led_b}, {5'd0, led_e});
        chk($sformatf("%s k%0d pulse", tag, k), {7'd0, bus.update_pulse}, {7'd0, pulse_e});
        chk($sformatf("%s k%0d busy", tag, k), {7'd0, bus.busy}, {7'd0, busy_e});
    endtask

    initial begin
        int cr, cg, cb;
        rst_n    = 1'b0;
        bus.duty = 4'hF;
        set_rgb(3'b000);

        // reset state
        repeat (3) next();
        chk_all("reset", 0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        next();
        next();
        chk_all("idle", 0, 3'b000, 1'b0, 1'b0);

        // first colour 110: SETTLE at 3, accept at 7, pulse/flash from 8
        set_rgb(3'b110);
        for (int k = 1; k <= 12; k++) begin
            next();
            chk_all("first", k, (k >= 8) ? 3'b110 : 3'b000, k == 8, (k >= 4 && k <= 10));
        end

        // PWM duty 4: 4 of 16 cycles per lit LED, blue dark
        bus.duty = 4'd4;
        next();
        next();
        cr = 0; cg = 0; cb = 0;
        for (int k = 0; k < 16; k++) begin
            next();
            cr += int'(bus.led_r); cg += int'(bus.led_g); cb += int'(bus.led_b);
        end
        chk("pwm4 r", 8'(cr), 8'd4);
        chk("pwm4 g", 8'(cg), 8'd4);
        chk("pwm4 b", 8'(cb), 8'd0);

        // duty 0: always off
        bus.duty = 4'd0;
        next();
        next();
        cr = 0; cg = 0;
        for (int k = 0; k < 16; k++) begin
            next();
            cr += int'(bus.led_r); cg += int'(bus.led_g);
        end
        chk("pwm0 r", 8'(cr), 8'd0);
        chk("pwm0 g", 8'(cg), 8'd0);

        // glitch: 101 for 2 cycles then back, withdrawn in SETTLE
        bus.duty = 4'hF;
        next();
        next();
        set_rgb(3'b101);
        for (int k = 1; k <= 12; k++) begin
            next();
            if (k == 2) set_rgb(3'b110);
            chk_all("glitch", k, 3'b110, 1'b0, (k == 4 || k == 5));
        end

        // 101 then 011 while settling: count restarts, single acceptance at 11
        set_rgb(3'b101);
        for (int k = 1; k <= 16; k++) begin
            next();
            if (k == 4) set_rgb(3'b011);
            chk_all("restart", k, (k >= 12) ? 3'b011 : 3'b110, k == 12, (k >= 4 && k <= 14));
        end

        // change during FLASH is held off until the first STEADY cycle
        set_rgb(3'b110);
        for (int k = 1; k <= 20; k++) begin
            next();
            if (k == 6) set_rgb(3'b101);
            chk_all("flashhold", k,
                    (k >= 16) ? 3'b101 : (k >= 8) ? 3'b110 : 3'b011,
                    (k == 8 || k == 16),
                    ((k >= 4 && k <= 10) || (k >= 12 && k <= 18)));
        end

        // reset mid-SETTLE, then mid-FLASH (on the cycle the pulse would show)
        set_rgb(3'b011);
        for (int k = 1; k <= 4; k++) begin
            next();
            if (k == 4) rst_n = 1'b0;
        end
        next();
        chk_all("rst_settle", 5, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 6; k <= 12; k++) begin
            next();
            chk_all("post_rst", k, 3'b000, 1'b0, k >= 9);
        end
        rst_n = 1'b0;
        next();
        chk_all("rst_flash", 13, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 14; k <= 16; k++) begin
            next();
            chk_all("post_rst2", k, 3'b000, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the 2-bit magnitude comparator. Consumes its red (a>=b), green (a<=b) and blue (a!=b) indications and drives the board RGB LED.
- Synchronises the indications and glitch-filters them, since switch bounce makes the comparator outputs chatter.
- Latches a stable colour and briefly flashes it at full brightness on each change, then holds it at a programmable PWM brightness.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty input.
- STABLE_CYCLES, 1000000, cycles the synchronised colour vector must stay constant before acceptance (>=2).
- FLASH_CYCLES, 5000000, cycles of full-brightness flash after acceptance (>=1).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- red_in  in  1  comparator red (a>=b); asynchronous to clk.
- green_in  in  1  comparator green (a<=b); asynchronous.
- blue_in  in  1  comparator blue (a!=b); asynchronous.
- duty  in  PWM_BITS  steady-state brightness; static, sampled every cycle.
- led_r  out  1  red LED drive, registered.
- led_g  out  1  green LED drive, registered.
- led_b  out  1  blue LED drive, registered.
- update_pulse  out  1  one-cycle pulse when a new colour is accepted.
- busy  out  1  high in SETTLE or FLASH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sync stages, cand, acc = 3'b000; state = STEADY; stable and flash counters = 0; PWM counter = 0.
  - All outputs 0.
- Synchroniser: 2-flop per bit on {red_in, green_in, blue_in} gives s = sync2. An input change is visible in s 2 edges later.
- PWM counter pwm_cnt: free-running, wraps at 2^PWM_BITS-1 -> 0. Never cleared by colour events. pwm_on = (duty == all-ones) | (pwm_cnt < duty), so duty=0 means always off and all-ones means always on.
- FSM STEADY:
  - if s != acc: go SETTLE, cand <= s, stable_cnt <= 0.
- FSM SETTLE:
  - if s == acc: go STEADY (change withdrawn); acc unchanged.
  - else if s != cand: cand <= s, stable_cnt <= 0.
  - else if stable_cnt == STABLE_CYCLES-1: acc <= cand, update_pulse <= 1 for one cycle, go FLASH, flash_cnt <= 0.
  - else stable_cnt++.
- FSM FLASH:
  - Inputs are ignored.
  - flash_cnt++; when flash_cnt == FLASH_CYCLES-1, go STEADY.
  - A pending input difference is detected on the first STEADY cycle.
- Outputs, registered (one cycle after the state/counter values):
  - FLASH: {led_r, led_g, led_b} = acc.
  - STEADY: acc & {3{pwm_on}}.
  - SETTLE: keeps the previous acc colour, PWM-gated. The new colour never appears before acceptance.
  - busy = (state != STEADY), registered with the same timing.
- Acceptance latency:
  - A clean input change at edge 0 enters SETTLE at edge 3.
  - acc updates at edge 3+STABLE_CYCLES.
  - update_pulse and the flash LED outputs are visible the cycle after acc updates.
- Reset mid-SETTLE or mid-FLASH: immediate return to the reset state. No pulse; LEDs 0 from the next edge.
- The comparator never produces 3'b000. After reset the first valid vector always triggers SETTLE and then a flash.
- Simultaneous bit changes are treated as a single vector change. An illegal vector (e.g. 3'b111) is filtered and displayed like any other.

Test Plan (PWM_BITS=4, STABLE_CYCLES=4, FLASH_CYCLES=3):
- Reset, then hold {r,g,b}=3'b110 (a==b) -> SETTLE at edge 3; update_pulse 1 cycle at edge 8; led=110 for 3 cycles; then STEADY with duty=4'hF -> led=110 constant.
- STEADY on 110, duty=4 -> each LED high exactly 4 of every 16 cycles while its acc bit=1; led_b stays 0.
- Accepted 110, input toggles to 101 for 2 cycles then back -> SETTLE entered, returns to STEADY, no update_pulse, acc stays 110.
- Accepted 110, input to 101 then 011 after 2 cycles in SETTLE -> stable count restarts; acc=011 only after 4 stable cycles on 011; exactly one pulse.
- Input changes during FLASH -> ignored until STEADY; new SETTLE starts on the first STEADY cycle.
- rst_n low for 1 edge mid-SETTLE and mid-FLASH -> all outputs 0 next cycle, no update_pulse, acc=000.
